// File: rtl/map_pkg.sv
// map_pkg: knot table and FSM state type shared by the forward brightness map and its inverse.
// No ports. The table is 17 monotonic knots that bound 16 linear segments.
package map_pkg;

  localparam int MAP_SEGS = 16;

  localparam logic [15:0] MAP_KNOT [0:16] = '{
    16'h0000, 16'h4898, 16'h637b, 16'h779d,
    16'h8853, 16'h96e0, 16'ha3ea, 16'hafcf,
    16'hbad0, 16'hc516, 16'hcec1, 16'hd7e8,
    16'he09e, 16'he8f1, 16'hf0ec, 16'hf899,
    16'hffff
  };

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DIFF,
    DIVIDE
  } unmap_state_t;

endpackage

// File: rtl/unmap_if.sv
// unmap_if: start/result handshake of the inverse brightness map.
// master drives mapped_light/get_unmap; slave returns light/light_valid/busy.
interface unmap_if;
  logic [15:0] mapped_light;
  logic        get_unmap;
  logic [15:0] light;
  logic        light_valid;
  logic        busy;

  modport master (
    output mapped_light, get_unmap,
    input  light, light_valid, busy
  );

  modport slave (
    input  mapped_light, get_unmap,
    output light, light_valid, busy
  );
endinterface

// File: rtl/unmap_div.sv
// unmap_div: restoring divider, FRAC_W quotient bits MSB first, one bit per cycle.
// Ports: sys_clk, sys_rst (async low), start/dividend/den in; q/done out (valid while done=1).
module unmap_div #(
  parameter int FRAC_W = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic [16+FRAC_W-1:0] dividend,
  input  logic [15:0]         den,
  output logic [FRAC_W-1:0]   q,
  output logic                done
);
  localparam int DW = 16 + FRAC_W;

  logic [DW-1:0]     rem;
  logic [DW-1:0]     dsh;
  logic [FRAC_W-1:0] qr;
  logic [3:0]        cnt;
  logic              run;
  logic              qbit;

  // q and done look one step ahead so the caller
  // can register the result on the final bit's edge.
  assign qbit = rem >= dsh;
  assign q    = (qr << 1) | FRAC_W'(qbit);
  assign done = run && (cnt == 4'd0);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rem <= '0;
      dsh <= '0;
      qr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      rem <= dividend;
      dsh <= DW'(den) << (FRAC_W - 1);
      qr  <= '0;
      cnt <= 4'(FRAC_W - 1);
      run <= 1'b1;
    end else if (run) begin
      if (qbit) rem <= rem - dsh;
      dsh <= dsh >> 1;
      qr  <= q;
      cnt <= cnt - 4'd1;
      if (cnt == 4'd0) run <= 1'b0;
    end
  end
endmodule

// File: rtl/unmap.sv
// unmap: inverse brightness map; segment search then divide gives {seg, frac, zeros}.
// Ports: sys_clk, sys_rst (async low), u (unmap_if.slave). Macro UNMAP_ROUND_EN: round-to-nearest.
import map_pkg::*;

module unmap #(
  parameter int FRAC_W = 4
) (
  input  logic    sys_clk,
  input  logic    sys_rst,
  unmap_if.slave  u
);
  localparam int DW = 16 + FRAC_W;

  unmap_state_t      state;
  logic [15:0]       target;
  logic [15:0]       left;
  logic [15:0]       right;
  logic [3:0]        seg;
  logic [4:0]        nxt;
  logic [15:0]       num;
  logic [15:0]       den;
  logic [DW-1:0]     dividend;
  logic [FRAC_W-1:0] q;
  logic              done;
  logic              start;
  logic [15:0]       code;

  assign nxt   = {1'b0, seg} + 5'd1;
  assign num   = target - left;
  assign den   = right - left;
  assign start = state == DIFF;

  // num * (2^F - 1) as a shift and subtract
`ifdef UNMAP_ROUND_EN
  assign dividend = {num, {FRAC_W{1'b0}}} - DW'(num)
                  + DW'(den >> 1);
`else
  assign dividend = {num, {FRAC_W{1'b0}}} - DW'(num);
`endif

  assign code = {seg, 12'h000}
              | (16'(q) << (12 - FRAC_W));

  unmap_div #(.FRAC_W(FRAC_W)) div (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .dividend (dividend),
    .den      (den),
    .q        (q),
    .done     (done)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state         <= IDLE;
      target        <= '0;
      left          <= '0;
      right         <= '0;
      seg           <= '0;
      u.light       <= '0;
      u.light_valid <= 1'b0;
      u.busy        <= 1'b0;
    end else begin
      u.light_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (u.get_unmap) begin
            target <= u.mapped_light;
            seg    <= '0;
            u.busy <= 1'b1;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (target < MAP_KNOT[nxt] ||
              seg == 4'(MAP_SEGS - 1)) begin
            left  <= MAP_KNOT[{1'b0, seg}];
            right <= MAP_KNOT[nxt];
            state <= DIFF;
          end else begin
            seg <= seg + 4'd1;
          end
        end
        DIFF: state <= DIVIDE;
        DIVIDE: begin
          if (done) begin
            u.light       <= code;
            u.light_valid <= 1'b1;
            u.busy        <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unmap.sv
// tb_unmap: scoreboard bench for unmap (FRAC_W=4); directed vectors, abort, re-pulse,
// and a round-trip sweep when UNMAP_ROUND_EN is defined.
module tb_unmap;
  localparam int F = 4;

`ifdef UNMAP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  localparam logic [15:0] K [0:16] = '{
    16'h0000, 16'h4898, 16'h637b, 16'h779d,
    16'h8853, 16'h96e0, 16'ha3ea, 16'hafcf,
    16'hbad0, 16'hc516, 16'hcec1, 16'hd7e8,
    16'he09e, 16'he8f1, 16'hf0ec, 16'hf899,
    16'hffff
  };

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   cyc = 0;

  unmap_if u();

  unmap #(.FRAC_W(F)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .u       (u)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] light;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (u.light_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(u.light_valid), 0);
        end else begin
          e = sb.pop_front();
          check("light", 32'(u.light), 32'(e.light));
          check("latency", cyc, e.edge_no);
        end
      end
    end
  endtask

  // Called at a negedge; the next posedge is edge 0.
  task automatic req(logic [15:0] v, logic [15:0] want, int k);
    exp_t e;
    e.light   = want;
    e.edge_no = cyc + 1 + k + F + 2;
    sb.push_back(e);
    u.mapped_light = v;
    u.get_unmap    = 1'b1;
    @(negedge sys_clk);
    u.get_unmap = 1'b0;
    check("busy_after_accept", 32'(u.busy), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(logic [15:0] v, logic [15:0] want, int k);
    req(v, want, k);
    drain();
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  initial begin
    int e0;
    int den;
    logic [15:0] m;
    logic [15:0] code;
    u.mapped_light = '0;
    u.get_unmap    = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge sys_clk);
    check("rst_light", 32'(u.light), 0);
    check("rst_busy", 32'(u.busy), 0);
    check("rst_valid", 32'(u.light_valid), 0);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("idle_busy", 32'(u.busy), 0);

    run(16'h0000, 16'h0000, 0);
    run(16'h4898, 16'h1000, 1);
    run(16'hFFFF, 16'hFF00, 15);
    run(16'h244C, RND ? 16'h0800 : 16'h0700, 0);
    run(16'h637A, RND ? 16'h1F00 : 16'h1E00, 1);
    run(16'h637B, 16'h2000, 2);
    run(16'hBAD0, 16'h8000, 8);
    run(16'h0001, 16'h0000, 0);
    run(16'hF898, RND ? 16'hEF00 : 16'hEE00, 14);
    run(16'hFFFE, RND ? 16'hFF00 : 16'hFE00, 15);
    run(16'hF899, 16'hF000, 15);

    // Starts at edges 3 and 10 are ignored; a start
    // in the strobe cycle is taken.
    e0 = cyc + 1;
    req(16'hFFFF, 16'hFF00, 15);
    wait_cyc(e0 + 2);
    u.mapped_light = 16'h0000;
    u.get_unmap    = 1'b1;
    @(negedge sys_clk);
    u.get_unmap = 1'b0;
    wait_cyc(e0 + 9);
    u.mapped_light = 16'h0000;
    u.get_unmap    = 1'b1;
    @(negedge sys_clk);
    u.get_unmap = 1'b0;
    wait_cyc(e0 + 21);
    check("strobe_cycle_valid", 32'(u.light_valid), 1);
    check("strobe_cycle_busy", 32'(u.busy), 0);
    req(16'h8853, 16'h4000, 4);
    drain();

    // Reset while the divider is running.
    e0 = cyc + 1;
    req(16'hFFFF, 16'hFF00, 15);
    wait_cyc(e0 + 19);
    sys_rst = 1'b0;
    sb.delete();
    #1;
    check("abort_light", 32'(u.light), 0);
    check("abort_busy", 32'(u.busy), 0);
    check("abort_valid", 32'(u.light_valid), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (25) @(negedge sys_clk);
    check("post_abort_light", 32'(u.light), 0);
    check("post_abort_busy", 32'(u.busy), 0);
    run(16'h4898, 16'h1000, 1);

`ifdef UNMAP_ROUND_EN
    // {s,15} maps onto knot s+1, the same value
    // as {s+1,0}; the inverse returns the latter.
    for (int s = 0; s < 16; s++) begin
      for (int f = 0; f < 16; f++) begin
        den  = int'(K[s+1]) - int'(K[s]);
        m    = K[s] + 16'((den * f) / 15);
        code = (f == 15 && s < 15)
             ? {4'(s + 1), 12'h000}
             : {4'(s), 4'(f), 8'h00};
        run(m, code, int'(code[15:12]));
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
